// File: rtl/r8b_pkg.sv
// Shared types and helpers for the r8b GPR strobe controller.
package r8b_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {IDLE, ASSERT, HOLD} rd_state_e;

    // Width of a register select able to address n one-hot lanes.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/r8b_gpr_ctrl_if.sv
// Operand-read, operand-response, writeback and GPR strobe signals of r8b_gpr_ctrl.
interface r8b_gpr_ctrl_if
    import r8b_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = sel_w(NUM_REGS)
) ();
    logic                op_valid;
    logic                op_ready;
    logic [ADDR_W-1:0]   op_lhs_sel;
    logic [ADDR_W-1:0]   op_rhs_sel;
    logic                op_rhs_en;
    logic                op_out_en;
    logic [DATA_W-1:0]   lhs_bus;
    logic [DATA_W-1:0]   rhs_bus;
    logic [DATA_W-1:0]   lhs_q;
    logic [DATA_W-1:0]   rhs_q;
    logic                opnd_valid;
    logic                opnd_ready;
    logic                wb_valid;
    logic                wb_ready;
    logic [ADDR_W-1:0]   wb_dst;
    logic [DATA_W-1:0]   wb_data;
    logic [DATA_W-1:0]   reg_in_bus;
    logic [NUM_REGS-1:0] reg_load;
    logic [NUM_REGS-1:0] assert_lhs;
    logic [NUM_REGS-1:0] assert_rhs;
    logic [NUM_REGS-1:0] reg_write;

    modport master (
        output op_valid, op_lhs_sel, op_rhs_sel, op_rhs_en, op_out_en,
        output lhs_bus, rhs_bus, opnd_ready, wb_valid, wb_dst, wb_data,
        input  op_ready, lhs_q, rhs_q, opnd_valid, wb_ready, reg_in_bus,
        input  reg_load, assert_lhs, assert_rhs, reg_write
    );

    modport slave (
        input  op_valid, op_lhs_sel, op_rhs_sel, op_rhs_en, op_out_en,
        input  lhs_bus, rhs_bus, opnd_ready, wb_valid, wb_dst, wb_data,
        output op_ready, lhs_q, rhs_q, opnd_valid, wb_ready, reg_in_bus,
        output reg_load, assert_lhs, assert_rhs, reg_write
    );
endinterface

// File: rtl/r8b_onehot_dec.sv
// Select-to-one-hot decoder; out-of-range selects decode to all zeros.
module r8b_onehot_dec #(
    parameter int ADDR_W   = 2,
    parameter int NUM_REGS = 4
) (
    input  logic [ADDR_W-1:0]   sel,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (en && sel == ADDR_W'(i)) onehot[i] = 1'b1;
    end
endmodule

// File: rtl/r8b_gpr_ctrl.sv
// Strobe sequencer for an array of falling-edge GPRs: operand reads and writebacks.
// Define R8B_GPR_CTRL_CHECK_EN for select range checking and a sticky err output.
module r8b_gpr_ctrl
    import r8b_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = sel_w(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    r8b_gpr_ctrl_if.slave bus
`ifdef R8B_GPR_CTRL_CHECK_EN
    ,
    output logic          err
`endif
);
    rd_state_e           state_q, state_d;
    logic [DATA_W-1:0]   lhs_q, lhs_d, rhs_q, rhs_d, in_q, in_d;
    logic                rhs_en_q, rhs_en_d;
    logic [NUM_REGS-1:0] alhs_q, alhs_d, arhs_q, arhs_d, wr_q, wr_d, load_q, load_d;
    logic                op_hs, wb_hs, op_ready, opnd_valid;
    logic                lhs_zero, rhs_zero;

`ifdef R8B_GPR_CTRL_CHECK_EN
    localparam logic [ADDR_W:0] NREG = (ADDR_W+1)'(NUM_REGS);
    logic lhs_ok, rhs_ok, wb_ok;
    logic lhs_bad_q, lhs_bad_d, rhs_bad_q, rhs_bad_d, err_q, err_d;

    assign lhs_ok   = {1'b0, bus.op_lhs_sel} < NREG;
    assign rhs_ok   = !bus.op_rhs_en || ({1'b0, bus.op_rhs_sel} < NREG);
    assign wb_ok    = {1'b0, bus.wb_dst} < NREG;
    assign lhs_zero = lhs_bad_q;
    assign rhs_zero = rhs_bad_q;
    assign err      = err_q;

    always_comb begin
        lhs_bad_d = lhs_bad_q;
        rhs_bad_d = rhs_bad_q;
        if (op_hs) begin
            lhs_bad_d = !lhs_ok;
            rhs_bad_d = !rhs_ok;
        end
        err_d = err_q | (op_hs & ~(lhs_ok & rhs_ok)) | (bus.wb_valid & ~wb_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lhs_bad_q <= 1'b0;
            rhs_bad_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            lhs_bad_q <= lhs_bad_d;
            rhs_bad_q <= rhs_bad_d;
            err_q     <= err_d;
        end
    end

    a_lhs_oh:  assert property (@(posedge clk) disable iff (rst) $onehot0(alhs_q));
    a_rhs_oh:  assert property (@(posedge clk) disable iff (rst) $onehot0(arhs_q));
    a_wr_oh:   assert property (@(posedge clk) disable iff (rst) $onehot0(wr_q));
    a_load_oh: assert property (@(posedge clk) disable iff (rst) $onehot0(load_q));
`else
    logic wb_ok;
    assign wb_ok    = 1'b1;
    assign lhs_zero = 1'b0;
    assign rhs_zero = 1'b0;
`endif

    assign op_hs = (state_q == IDLE) && bus.op_valid;
    assign wb_hs = bus.wb_valid && wb_ok;

    // Strobes are decoded from the request and registered, so they are high
    // for exactly the ASSERT cycle and steady across the GPR sampling negedge.
    r8b_onehot_dec #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_dec_lhs (
        .sel(bus.op_lhs_sel), .en(op_hs),                   .onehot(alhs_d));
    r8b_onehot_dec #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_dec_rhs (
        .sel(bus.op_rhs_sel), .en(op_hs && bus.op_rhs_en),  .onehot(arhs_d));
    r8b_onehot_dec #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_dec_wr (
        .sel(bus.op_lhs_sel), .en(op_hs && bus.op_out_en),  .onehot(wr_d));
    r8b_onehot_dec #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_dec_ld (
        .sel(bus.wb_dst),     .en(wb_hs),                   .onehot(load_d));

    always_comb begin
        state_d    = state_q;
        lhs_d      = lhs_q;
        rhs_d      = rhs_q;
        rhs_en_d   = rhs_en_q;
        op_ready   = 1'b0;
        opnd_valid = 1'b0;
        case (state_q)
            IDLE: begin
                op_ready = 1'b1;
                if (bus.op_valid) begin
                    state_d  = ASSERT;
                    rhs_en_d = bus.op_rhs_en;
                end
            end
            ASSERT: begin
                state_d = HOLD;
                lhs_d   = lhs_zero ? '0 : bus.lhs_bus;
                rhs_d   = (rhs_en_q && !rhs_zero) ? bus.rhs_bus : '0;
            end
            HOLD: begin
                opnd_valid = 1'b1;
                if (bus.opnd_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // reg_in_bus keeps the last written value between writebacks.
    assign in_d = wb_hs ? bus.wb_data : in_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            lhs_q    <= '0;
            rhs_q    <= '0;
            rhs_en_q <= 1'b0;
            in_q     <= '0;
            alhs_q   <= '0;
            arhs_q   <= '0;
            wr_q     <= '0;
            load_q   <= '0;
        end else begin
            state_q  <= state_d;
            lhs_q    <= lhs_d;
            rhs_q    <= rhs_d;
            rhs_en_q <= rhs_en_d;
            in_q     <= in_d;
            alhs_q   <= alhs_d;
            arhs_q   <= arhs_d;
            wr_q     <= wr_d;
            load_q   <= load_d;
        end
    end

    assign bus.op_ready   = op_ready;
    assign bus.opnd_valid = opnd_valid;
    assign bus.lhs_q      = lhs_q;
    assign bus.rhs_q      = rhs_q;
    assign bus.wb_ready   = 1'b1;
    assign bus.reg_in_bus = in_q;
    assign bus.reg_load   = load_q;
    assign bus.assert_lhs = alhs_q;
    assign bus.assert_rhs = arhs_q;
    assign bus.reg_write  = wr_q;
endmodule

// File: tb/tb_r8b_gpr_ctrl.sv
// Scoreboard bench for r8b_gpr_ctrl: directed then random traffic against a register-array model.
module tb_r8b_gpr_ctrl;
    localparam int NR = 4;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam logic [DW-1:0] FLOAT = 8'hA5;  // value seen on a bus nobody drives

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    r8b_gpr_ctrl_if #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW)) bus_if ();
`ifdef R8B_GPR_CTRL_CHECK_EN
    logic err;
`endif

    r8b_gpr_ctrl #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
`ifdef R8B_GPR_CTRL_CHECK_EN
        ,
        .err(err)
`endif
    );

    // GPR array environment: load on negedge, drive buses from strobes.
    logic [DW-1:0] gpr [NR] = '{default: '0};
    always @(negedge clk)
        for (int i = 0; i < NR; i++)
            if (bus_if.reg_load[i]) gpr[i] <= bus_if.reg_in_bus;

    always_comb begin
        bus_if.lhs_bus = FLOAT;
        bus_if.rhs_bus = FLOAT;
        for (int i = 0; i < NR; i++) begin
            if (bus_if.assert_lhs[i]) bus_if.lhs_bus = gpr[i];
            if (bus_if.assert_rhs[i]) bus_if.rhs_bus = gpr[i];
        end
    end

    typedef struct {
        bit            op_ready;
        bit            opnd_valid;
        logic [NR-1:0] alhs, arhs, wr, load;
        logic [DW-1:0] in_val;
        bit            in_known;
        bit            err;
    } cyc_exp_t;

    typedef struct {
        logic [DW-1:0] l, r;
    } opnd_t;

    cyc_exp_t cq[$];
    opnd_t    oq[$];
    int  n_cmp = 0, n_bad = 0;
    bit  mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NR-1:0] oh(input int s);
        return (s < NR) ? (NR'(1) << s) : '0;
    endfunction

    function automatic int rsel();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(NR, 7));
        return int'($urandom_range(0, NR - 1));
    endfunction

    // Monitor: per-cycle expectations plus operand scoreboard on the consume handshake.
    always @(negedge clk) begin
        if (mon_en && cq.size() != 0) begin
            cyc_exp_t e;
            e = cq.pop_front();
            chk("op_ready",   32'(bus_if.op_ready),   32'(e.op_ready));
            chk("opnd_valid", 32'(bus_if.opnd_valid), 32'(e.opnd_valid));
            chk("wb_ready",   32'(bus_if.wb_ready),   32'd1);
            chk("assert_lhs", 32'(bus_if.assert_lhs), 32'(e.alhs));
            chk("assert_rhs", 32'(bus_if.assert_rhs), 32'(e.arhs));
            chk("reg_write",  32'(bus_if.reg_write),  32'(e.wr));
            chk("reg_load",   32'(bus_if.reg_load),   32'(e.load));
            if (e.in_known) chk("reg_in_bus", 32'(bus_if.reg_in_bus), 32'(e.in_val));
`ifdef R8B_GPR_CTRL_CHECK_EN
            chk("err", 32'(err), 32'(e.err));
`endif
            if (bus_if.opnd_valid && bus_if.opnd_ready) begin
                if (oq.size() == 0) begin
                    chk("opnd_unexpected", 32'(bus_if.opnd_valid), 32'd0);
                end else begin
                    opnd_t o;
                    o = oq.pop_front();
                    chk("lhs_q", 32'(bus_if.lhs_q), 32'(o.l));
                    chk("rhs_q", 32'(bus_if.rhs_q), 32'(o.r));
                end
            end
        end
    end

    // Reference model state
    logic [DW-1:0] mem [NR];
    bit            outstanding = 1'b0;
    int            acc_cyc = 0;
    logic [NR-1:0] p_alhs = '0, p_arhs = '0, p_wr = '0, p_load = '0;
    logic [DW-1:0] last_in = '0;
    bit            in_known = 1'b1;
    bit            err_m = 1'b0;

    task automatic drive(input bit ov, input int lhs, input int rhs, input bit ren, input bit oen,
                         input bit ordy, input bit wv, input int dst, input int data);
        bus_if.op_valid   = ov;
        bus_if.op_lhs_sel = AW'(lhs);
        bus_if.op_rhs_sel = AW'(rhs);
        bus_if.op_rhs_en  = ren;
        bus_if.op_out_en  = oen;
        bus_if.opnd_ready = ordy;
        bus_if.wb_valid   = wv;
        bus_if.wb_dst     = AW'(dst);
        bus_if.wb_data    = DW'(data);
    endtask

    function automatic logic [DW-1:0] rd_val(input int s);
`ifdef R8B_GPR_CTRL_CHECK_EN
        return (s < NR) ? mem[s] : '0;
`else
        return (s < NR) ? mem[s] : FLOAT;
`endif
    endfunction

    initial begin
        cyc_exp_t e;
        opnd_t    o;
        bit ov, ren, oen, ordy, wv;
        int lhs, rhs, dst, data;
        for (int i = 0; i < NR; i++) mem[i] = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_op_ready",   32'(bus_if.op_ready),   32'd1);
        chk("rst_wb_ready",   32'(bus_if.wb_ready),   32'd1);
        chk("rst_opnd_valid", 32'(bus_if.opnd_valid), 32'd0);
        chk("rst_strobes", 32'({bus_if.assert_lhs, bus_if.assert_rhs, bus_if.reg_write, bus_if.reg_load}), 32'd0);
        chk("rst_lhs_q",      32'(bus_if.lhs_q),      32'd0);
        rst = 1'b0;

        // Reset in the middle of ASSERT, with a writeback pending in the same cycle
        @(posedge clk); #1;
        drive(1, 1, 2, 1, 1, 0, 1, 2, 8'h77);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mid_assert_lhs", 32'(bus_if.assert_lhs), 32'(4'b0010));
        chk("mid_assert_rhs", 32'(bus_if.assert_rhs), 32'(4'b0100));
        chk("mid_reg_load",   32'(bus_if.reg_load),   32'(4'b0100));
        #2 rst = 1'b1;
        #1;
        chk("arst_strobes", 32'({bus_if.assert_lhs, bus_if.assert_rhs, bus_if.reg_write, bus_if.reg_load}), 32'd0);
        chk("arst_opnd_valid", 32'(bus_if.opnd_valid), 32'd0);
        chk("arst_op_ready",   32'(bus_if.op_ready),   32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        mon_en = 1'b1;
        for (int cyc = 0; cyc < 620; cyc++) begin
            e.op_ready   = !outstanding;
            e.opnd_valid = outstanding && (cyc >= acc_cyc + 2);
            e.alhs = p_alhs; e.arhs = p_arhs; e.wr = p_wr; e.load = p_load;
            e.in_val = last_in; e.in_known = in_known; e.err = err_m;
            cq.push_back(e);

            ov = 0; lhs = 0; rhs = 0; ren = 0; oen = 0; ordy = 0; wv = 0; dst = 0; data = 0;
            case (cyc)
                0:  begin wv = 1; dst = 1; data = 8'h11; end
                1:  begin wv = 1; dst = 3; data = 8'h33; end
                2:  begin wv = 1; dst = 2; data = 8'h5A; end
                3:  begin ov = 1; lhs = 1; rhs = 3; ren = 1; end
                6:  begin ov = 1; lhs = 2; end
                10: ordy = 1;
                11: begin ov = 1; lhs = 0; rhs = 0; ren = 1; oen = 1; ordy = 1;
                          wv = 1; dst = 0; data = 8'hC3; end
                12, 13, 15, 16: ordy = 1;
                14: begin ov = 1; lhs = 5; rhs = 6; ren = 1; ordy = 1; end
                17: begin wv = 1; dst = 7; data = 8'h99; ordy = 1; end
                default: begin
                    if (cyc >= 20 && cyc < 600) begin
                        ov = $urandom_range(0, 1) == 1;
                        lhs = rsel(); rhs = rsel();
                        ren = $urandom_range(0, 1) == 1;
                        oen = $urandom_range(0, 1) == 1;
                        ordy = $urandom_range(0, 2) != 0;
                        wv = $urandom_range(0, 1) == 1;
                        dst = rsel();
                        data = int'($urandom_range(0, 255));
                    end else begin
                        ordy = 1;
                    end
                end
            endcase
            drive(ov, lhs, rhs, ren, oen, ordy, wv, dst, data);

            // Effects of the handshakes at the coming posedge; writes land before reads sample
            p_alhs = '0; p_arhs = '0; p_wr = '0; p_load = '0;
            if (ordy && e.opnd_valid) outstanding = 1'b0;
            if (wv) begin
                if (dst < NR) begin
                    p_load = oh(dst);
                    mem[dst] = DW'(data);
                    last_in = DW'(data);
                    in_known = 1'b1;
                end else begin
`ifdef R8B_GPR_CTRL_CHECK_EN
                    err_m = 1'b1;
`else
                    in_known = 1'b0;
`endif
                end
            end
            if (ov && e.op_ready) begin
                p_alhs = oh(lhs);
                p_arhs = ren ? oh(rhs) : '0;
                p_wr   = oen ? oh(lhs) : '0;
                outstanding = 1'b1;
                acc_cyc = cyc;
                o.l = rd_val(lhs);
                o.r = ren ? rd_val(rhs) : '0;
                oq.push_back(o);
`ifdef R8B_GPR_CTRL_CHECK_EN
                if (lhs >= NR || (ren && rhs >= NR)) err_m = 1'b1;
`endif
            end
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        mon_en = 1'b0;
        chk("opnd_drained", 32'(oq.size()), 32'd0);

        // Final reset clears operands, the RegIn bus and (when present) err
        rst = 1'b1;
        #1;
        chk("end_rst_lhs_q",  32'(bus_if.lhs_q),      32'd0);
        chk("end_rst_rhs_q",  32'(bus_if.rhs_q),      32'd0);
        chk("end_rst_reg_in", 32'(bus_if.reg_in_bus), 32'd0);
`ifdef R8B_GPR_CTRL_CHECK_EN
        chk("end_rst_err",    32'(err),               32'd0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
